// File: rtl/dspl_scan_8_if.sv
// Bundle between the game FSM (master) and the 8-digit display scanner (slave):
// eight 6-bit digit codes and a blink request in, anode/cathode drive and frame pulse out.
interface dspl_scan_8_if;
   logic [5:0] d1;
   logic [5:0] d2;
   logic [5:0] d3;
   logic [5:0] d4;
   logic [5:0] d5;
   logic [5:0] d6;
   logic [5:0] d7;
   logic [5:0] d8;
   logic       blink;
   logic [7:0] an;
   logic [7:0] seg;
   logic       frame_tick;

   modport master (
      output d1, d2, d3, d4, d5, d6, d7, d8, blink,
      input  an, seg, frame_tick
   );

   modport slave (
      input  d1, d2, d3, d4, d5, d6, d7, d8, blink,
      output an, seg, frame_tick
   );
endinterface

// File: rtl/dspl_scan_8.sv
// Time-multiplexed 8-digit common-anode 7-segment driver with per-frame code snapshot.
// Optional blink blanking is compiled in when DSPL_BLINK_EN is defined.
module dspl_scan_8 #(
   parameter int REFRESH_DIV  = 100000,
   parameter int BLINK_FRAMES = 64
) (
   input logic          clock,
   input logic          reset,
   dspl_scan_8_if.slave bus
);

   localparam int PW = $clog2(REFRESH_DIV);

   logic [PW-1:0] presc_q, presc_d;
   logic [2:0]    idx_q, idx_d;
   logic [5:0]    shadow_q [8];
   logic [5:0]    shadow_d [8];
   logic [5:0]    live [8];
   logic [7:0]    an_q, an_d;
   logic [7:0]    seg_q, seg_d;
   logic          ft_q, ft_d;
   logic          tick, snap, blank;
   logic [5:0]    code;

   function automatic logic [7:0] decode(input logic [5:0] c);
      logic [6:0] g;
      g = 7'h7F;
      case (c[4:1])
         4'h0: g = 7'h40;
         4'h1: g = 7'h79;
         4'h2: g = 7'h24;
         4'h3: g = 7'h30;
         4'h4: g = 7'h19;
         4'h5: g = 7'h12;
         4'h6: g = 7'h02;
         4'h7: g = 7'h78;
         4'h8: g = 7'h00;
         4'h9: g = 7'h10;
         4'hA: g = 7'h08;
         4'hB: g = 7'h03;
         4'hC: g = 7'h46;
         4'hD: g = 7'h21;
         4'hE: g = 7'h06;
         4'hF: g = 7'h0E;
         default: g = 7'h7F;
      endcase
      return c[5] ? 8'hBF : {~c[0], g};
   endfunction

   always_comb begin
      live[0] = bus.d1;
      live[1] = bus.d2;
      live[2] = bus.d3;
      live[3] = bus.d4;
      live[4] = bus.d5;
      live[5] = bus.d6;
      live[6] = bus.d7;
      live[7] = bus.d8;
   end

   assign tick = (presc_q == PW'(REFRESH_DIV - 1));
   // The wrap from digit 7 to digit 0 is the frame boundary.
   assign snap = tick && (idx_q == 3'd7);

`ifdef DSPL_BLINK_EN
   localparam int FW = $clog2(BLINK_FRAMES + 1);

   logic [FW-1:0] fcnt_q, fcnt_d;
   logic          phase_q, phase_d;

   // fcnt runs 1..BLINK_FRAMES across snapshots; phase flips when a new run starts.
   always_comb begin
      fcnt_d  = fcnt_q;
      phase_d = phase_q;
      if (!bus.blink) begin
         fcnt_d  = '0;
         phase_d = 1'b0;
      end else if (snap) begin
         if (fcnt_q == FW'(BLINK_FRAMES)) begin
            fcnt_d  = FW'(1);
            phase_d = ~phase_q;
         end else begin
            fcnt_d = fcnt_q + FW'(1);
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         fcnt_q  <= '0;
         phase_q <= 1'b0;
      end else begin
         fcnt_q  <= fcnt_d;
         phase_q <= phase_d;
      end
   end

   assign blank = bus.blink & phase_d;
`else
   localparam int unused_blink_frames = BLINK_FRAMES;
   logic unused_blink;
   assign unused_blink = bus.blink;
   assign blank        = 1'b0;
`endif

   always_comb begin
      presc_d  = tick ? '0 : presc_q + PW'(1);
      idx_d    = idx_q;
      shadow_d = shadow_q;
      an_d     = an_q;
      seg_d    = seg_q;
      ft_d     = 1'b0;
      code     = shadow_q[0];
      if (tick) begin
         idx_d = idx_q + 3'd1;
         code  = shadow_q[idx_d];
         // Digit 0 shows the freshly sampled code, not last frame's copy.
         if (snap) begin
            shadow_d = live;
            code     = live[0];
            ft_d     = 1'b1;
         end
         an_d  = blank ? 8'hFF : ~(8'b1 << idx_d);
         seg_d = decode(code);
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         presc_q <= '0;
         idx_q   <= 3'd7;
         for (int k = 0; k < 8; k++) shadow_q[k] <= 6'b111111;
         an_q    <= 8'hFF;
         seg_q   <= 8'hFF;
         ft_q    <= 1'b0;
      end else begin
         presc_q  <= presc_d;
         idx_q    <= idx_d;
         shadow_q <= shadow_d;
         an_q     <= an_d;
         seg_q    <= seg_d;
         ft_q     <= ft_d;
      end
   end

   assign bus.an         = an_q;
   assign bus.seg        = seg_q;
   assign bus.frame_tick = ft_q;

endmodule
